// File: rtl/matmul_job_scheduler_if.sv
// matmul_job_scheduler_if: requester, engine and response signals of the matmul job scheduler
interface matmul_job_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_WIDTH  = $clog2(NUM_REQ),
  parameter int SIZE_COUNT = 8,
  parameter int SIZE_WIDTH = $clog2(SIZE_COUNT),
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0][0:1][SIZE_WIDTH-1:0] req_a_size;
  logic [NUM_REQ-1:0][0:1][SIZE_WIDTH-1:0] req_b_size;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_a_base;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_b_base;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_c_base;
  logic eng_start;
  logic [0:1][SIZE_WIDTH-1:0] eng_a_size;
  logic [0:1][SIZE_WIDTH-1:0] eng_b_size;
  logic [ADDR_WIDTH-1:0] eng_a_base;
  logic [ADDR_WIDTH-1:0] eng_b_base;
  logic [ADDR_WIDTH-1:0] eng_c_base;
  logic eng_busy;
  logic resp_valid;
  logic resp_ready;
  logic [REQ_WIDTH-1:0] resp_id;
  logic [1:0] resp_status;
  logic sched_busy;
  modport master (
    input  req_valid, req_a_size, req_b_size, req_a_base, req_b_base, req_c_base, eng_busy, resp_ready,
    output req_ready, eng_start, eng_a_size, eng_b_size, eng_a_base, eng_b_base, eng_c_base,
           resp_valid, resp_id, resp_status, sched_busy
  );
  modport slave (
    output req_valid, req_a_size, req_b_size, req_a_base, req_b_base, req_c_base, eng_busy, resp_ready,
    input  req_ready, eng_start, eng_a_size, eng_b_size, eng_a_base, eng_b_base, eng_c_base,
           resp_valid, resp_id, resp_status, sched_busy
  );
endinterface

// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler: round-robin sharing of one matrix-multiply engine among requesters
module matmul_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_WIDTH      = $clog2(NUM_REQ),
  parameter int SIZE_COUNT     = 8,
  parameter int SIZE_WIDTH     = $clog2(SIZE_COUNT),
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int START_WAIT     = 4
) (
  input logic clk,
  input logic reset,
  matmul_job_scheduler_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + START_WAIT) + 1;
  typedef enum logic [2:0] {IDLE, CHECK, START, WAIT_BUSY, RUN, RESP} state_t;
  state_t state_q, state_d;
  logic [REQ_WIDTH-1:0] last_grant, gnt_id, cand, id_q;
  logic gnt_any, grant;
  logic [0:1][SIZE_WIDTH-1:0] a_size_q, b_size_q;
  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
  logic [CW-1:0] cnt;
  logic [1:0] status_q, status_d;
  // search from last_grant+1 around the ring; the nearest valid requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = REQ_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign grant = state_q == IDLE && gnt_any;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // next state and completion status
  always_comb begin
    state_d = state_q;
    status_d = status_q;
    case (state_q)
      IDLE: state_d = gnt_any ? CHECK : IDLE;
      CHECK: begin
        state_d = a_size_q[1] != b_size_q[0] ? RESP : START;
        status_d = a_size_q[1] != b_size_q[0] ? 2'd1 : status_q;
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (bus.eng_busy) state_d = RUN;
        else if (cnt == CW'(START_WAIT - 1)) begin
          state_d = RESP;
          status_d = 2'd2;
        end
      RUN:
        if (!bus.eng_busy) begin
          state_d = RESP;
          status_d = 2'd0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          status_d = 2'd3;
        end
      RESP: state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // descriptor latch on grant, grant pointer, saturating phase counter cleared on every state change
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_grant <= REQ_WIDTH'(NUM_REQ - 1);
      id_q <= '0;
      a_size_q <= '0;
      b_size_q <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      cnt <= '0;
      status_q <= '0;
    end else begin
      status_q <= status_d;
      cnt <= state_d != state_q ? '0 : (&cnt ? cnt : cnt + 1'b1);
      if (grant) begin
        last_grant <= gnt_id;
        id_q <= gnt_id;
        a_size_q <= bus.req_a_size[gnt_id];
        b_size_q <= bus.req_b_size[gnt_id];
        a_base_q <= bus.req_a_base[gnt_id];
        b_base_q <= bus.req_b_base[gnt_id];
        c_base_q <= bus.req_c_base[gnt_id];
      end
    end
  assign bus.req_ready = (grant && reset) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id : '0;
  assign bus.eng_start = state_q == START;
  assign bus.eng_a_size = a_size_q;
  assign bus.eng_b_size = b_size_q;
  assign bus.eng_a_base = a_base_q;
  assign bus.eng_b_base = b_base_q;
  assign bus.eng_c_base = c_base_q;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_id = id_q;
  assign bus.resp_status = status_q;
  assign bus.sched_busy = state_q != IDLE;
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// tb_matmul_job_scheduler: descriptor table, scoreboarded responses and multi-cycle corner sequences
module tb_matmul_job_scheduler;
  localparam int NUM_REQ = 4;
  localparam int START_WAIT = 4;
  localparam int TIMEOUT_CYCLES = 1024;
  typedef struct {
    int id;
    logic [5:0] a;
    logic [5:0] b;
    int dly;
    int len;
    int status;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  matmul_job_scheduler_if bus();
  matmul_job_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .START_WAIT(START_WAIT))
    dut (.clk(clk), .reset(reset), .bus(bus.master));
  int n_checks = 0, n_fail = 0, n_start = 0, cyc = 0;
  int t_start = 0, t_resp = 0, t_grant = 0, t_hs = 0;
  int eng_dly = 0, eng_len = 0;
  logic resp_prev = 1'b0;
  int grant_q[$];
  logic [3:0] sb[$];
  logic [31:0] ab[NUM_REQ], bb[NUM_REQ], cb[NUM_REQ];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.req_ready, bus.eng_start, bus.eng_a_size, bus.eng_b_size, bus.eng_a_base, bus.eng_b_base,
             bus.eng_c_base, bus.resp_valid, bus.resp_id, bus.resp_status, bus.sched_busy};
  endfunction

  // monitor: grants, engine starts, response timing and scoreboard pops
  always @(negedge clk) begin
    cyc++;
    if (|bus.req_ready) begin
      chk("req_ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) grant_q.push_back(i);
      t_grant = cyc;
    end
    if (bus.eng_start) begin
      n_start++;
      t_start = cyc;
    end
    if (bus.resp_valid && !resp_prev) t_resp = cyc;
    resp_prev = bus.resp_valid;
    if (bus.resp_valid && bus.resp_ready) begin
      t_hs = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: id %0d status %0d with no job outstanding", bus.resp_id, bus.resp_status);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(e[3:2]));
        chk("resp_status", 64'(bus.resp_status), 64'(e[1:0]));
      end
    end
  end

  // engine model: after a start, busy rises eng_dly cycles later for eng_len cycles (eng_dly 0: never)
  initial begin
    bus.eng_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.eng_start && eng_dly > 0) begin
        repeat (eng_dly) @(posedge clk);
        #1 bus.eng_busy = 1'b1;
        repeat (eng_len) @(posedge clk);
        #1 bus.eng_busy = 1'b0;
      end
    end
  end

  task automatic set_req(input int id, input logic [5:0] a, input logic [5:0] b);
    ab[id] = $urandom;
    bb[id] = $urandom;
    cb[id] = $urandom;
    bus.req_a_size[id] = a;
    bus.req_b_size[id] = b;
    bus.req_a_base[id] = ab[id];
    bus.req_b_base[id] = bb[id];
    bus.req_c_base[id] = cb[id];
  endtask

  task automatic req_job(input int id, input logic [5:0] a, input logic [5:0] b);
    int g0 = grant_q.size();
    set_req(id, a, b);
    bus.req_valid[id] = 1'b1;
    for (int k = 0; k < 50 && grant_q.size() == g0; k++) @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    chk("grant_id", 64'(grant_q.size() > g0 ? grant_q[$] : -1), 64'(id));
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) @(posedge clk);
    #1 chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_eng_idle();
    for (int k = 0; k < 300 && bus.eng_busy; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s0, exp_lat;
    logic stable;
    logic [3:0] cap;
    tbl[0] = '{2, {3'd1, 3'd2}, {3'd2, 3'd3}, 1, 6, 0};
    tbl[1] = '{0, {3'd0, 3'd3}, {3'd2, 3'd0}, 1, 3, 1};
    tbl[2] = '{1, {3'd7, 3'd7}, {3'd7, 3'd7}, 1, 1, 0};
    tbl[3] = '{3, {3'd2, 3'd0}, {3'd0, 3'd5}, 0, 0, 2};
    tbl[4] = '{2, {3'd3, 3'd4}, {3'd4, 3'd1}, 3, 4, 0};
    tbl[5] = '{1, {3'd5, 3'd6}, {3'd6, 3'd0}, 4, 2, 0};
    tbl[6] = '{0, {3'd0, 3'd0}, {3'd0, 3'd7}, 1, 1100, 3};
    tbl[7] = '{3, {3'd1, 3'd1}, {3'd1, 3'd1}, 5, 3, 2};
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_a_size = '0;
    bus.req_b_size = '0;
    bus.req_a_base = '0;
    bus.req_b_base = '0;
    bus.req_c_base = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 64'(any_out()), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("idle_sched_busy", 64'(bus.sched_busy), 64'd0);

    // all requesters valid continuously: strict 0,1,2,3 rotation
    eng_dly = 1;
    eng_len = 2;
    for (int i = 0; i < 8; i++) sb.push_back({2'(i % 4), 2'd0});
    for (int i = 0; i < NUM_REQ; i++) set_req(i, {3'd1, 3'd2}, {3'd2, 3'd1});
    g = grant_q.size();
    bus.req_valid = '1;
    for (int k = 0; k < 600 && grant_q.size() - g < 8; k++) @(posedge clk);
    #1 bus.req_valid = '0;
    for (int i = 0; i < 8; i++)
      chk("rr_order", 64'(grant_q.size() > g + i ? grant_q[g + i] : -1), 64'(i % 4));
    wait_drain(100);

    // descriptor table
    for (int i = 0; i < 8; i++) begin
      eng_dly = tbl[i].dly;
      eng_len = tbl[i].len;
      s0 = n_start;
      sb.push_back({2'(tbl[i].id), 2'(tbl[i].status)});
      req_job(tbl[i].id, tbl[i].a, tbl[i].b);
      chk("eng_sizes", 64'({bus.eng_a_size, bus.eng_b_size}), 64'({tbl[i].a, tbl[i].b}));
      chk("eng_ab_base", {bus.eng_a_base, bus.eng_b_base}, {ab[tbl[i].id], bb[tbl[i].id]});
      chk("eng_c_base", 64'(bus.eng_c_base), 64'(cb[tbl[i].id]));
      wait_drain(1500);
      chk("eng_sizes_held", 64'({bus.eng_a_size, bus.eng_b_size}), 64'({tbl[i].a, tbl[i].b}));
      chk("start_count", 64'(n_start - s0), 64'(tbl[i].status == 1 ? 0 : 1));
      if (tbl[i].status == 1) chk("mismatch_resp_delay", 64'(t_resp - t_grant), 64'd2);
      else begin
        exp_lat = tbl[i].status == 0 ? tbl[i].dly + tbl[i].len + 1 :
                  tbl[i].status == 2 ? START_WAIT + 1 : tbl[i].dly + 1 + TIMEOUT_CYCLES;
        chk("start_after_grant", 64'(t_start - t_grant), 64'd2);
        chk("resp_latency", 64'(t_resp - t_start), 64'(exp_lat));
      end
      if (tbl[i].status == 3) begin
        repeat (3) @(posedge clk);
        #1 chk("idle_ignores_busy", 64'({bus.eng_busy, bus.sched_busy, bus.resp_valid}), 64'(3'b100));
      end
      wait_eng_idle();
    end

    // response back-pressure with requester 1 pending
    bus.resp_ready = 1'b0;
    eng_dly = 1;
    eng_len = 3;
    sb.push_back({2'd0, 2'd0});
    req_job(0, {3'd2, 3'd4}, {3'd4, 3'd2});
    set_req(1, {3'd3, 3'd3}, {3'd3, 3'd3});
    sb.push_back({2'd1, 2'd0});
    bus.req_valid[1] = 1'b1;
    for (int k = 0; k < 40 && !bus.resp_valid; k++) begin
      @(posedge clk);
      #1;
    end
    g = grant_q.size();
    cap = {bus.resp_id, bus.resp_status};
    chk("stall_resp", 64'({bus.resp_valid, cap}), 64'(5'b10000));
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1 if (!bus.resp_valid || {bus.resp_id, bus.resp_status} != cap || bus.req_ready != '0) stable = 1'b0;
    end
    chk("stall_resp_stable", 64'(stable), 64'd1);
    chk("stall_no_grant", 64'(grant_q.size()), 64'(g));
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 20 && grant_q.size() == g; k++) @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    chk("stall_then_req1", 64'(grant_q.size() > g ? grant_q[$] : -1), 64'd1);
    chk("grant_after_handshake", 64'(t_grant > t_hs), 64'd1);
    wait_drain(100);
    wait_eng_idle();

    // reset in the middle of RUN
    eng_dly = 1;
    eng_len = 30;
    sb.push_back({2'd3, 2'd0});
    req_job(3, {3'd1, 3'd1}, {3'd1, 3'd1});
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    sb.delete();
    #1 chk("reset_async_outputs", 64'(any_out()), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_eng_idle();
    chk("no_resp_after_abort", 64'(bus.resp_valid), 64'd0);
    eng_dly = 1;
    eng_len = 2;
    sb.push_back({2'd0, 2'd0});
    sb.push_back({2'd2, 2'd0});
    set_req(0, {3'd1, 3'd2}, {3'd2, 3'd1});
    set_req(2, {3'd1, 3'd2}, {3'd2, 3'd1});
    g = grant_q.size();
    bus.req_valid[0] = 1'b1;
    bus.req_valid[2] = 1'b1;
    for (int k = 0; k < 20 && grant_q.size() == g; k++) @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    chk("post_reset_first", 64'(grant_q.size() > g ? grant_q[$] : -1), 64'd0);
    for (int k = 0; k < 40 && grant_q.size() == g + 1; k++) @(posedge clk);
    #1 bus.req_valid[2] = 1'b0;
    chk("post_reset_second", 64'(grant_q.size() > g + 1 ? grant_q[$] : -1), 64'd2);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
